credit_rx_buffer: RTL and testbench
===================================

CREDIT_RX_BUFFER -- requirements
Module: credit_rx_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: buffer entries, power of two, at least 2.
REQ-003 SHALL have parameter THRESHOLD, default 4: pending credits that force a credit message, range 1..DEPTH.
REQ-004 SHALL have parameter TIMEOUT, default 16: cycles a nonzero pending count waits before flush, at least 1.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  payload from the ARQ receiver output; no ready signal, always accepted.
REQ-008 in_payload  input  WIDTH  data accompanying in_valid.
REQ-009 out_valid  output  1  buffered payload available to the consumer.
REQ-010 out_ready  input  1  consumer accepts; handshake is out_valid && out_ready.
REQ-011 out_payload  output  WIDTH  oldest buffered entry.
REQ-012 credit_valid  output  1  credit message offered toward the ARQ sender input.
REQ-013 credit_ready  input  1  credit message accepted; handshake is credit_valid && credit_ready.
REQ-014 credit_count  output  $clog2(DEPTH+1)  number of credits returned by the message.
REQ-015 overflow  output  1  sticky flag: a write arrived while no slot was free.

Function
REQ-016 Buffer SHALL be FIFO-ordered; a write in cycle N is visible on out_valid in cycle N+1 (no bypass).
REQ-017 Write SHALL be accepted when occupancy < DEPTH, or when occupancy == DEPTH and an out handshake happens the same cycle.
REQ-018 Write with no free slot SHALL be dropped without state change except overflow <= 1, held until reset.
REQ-019 out_valid SHALL equal (occupancy != 0); out_payload SHALL be stable while out_valid && !out_ready.
REQ-020 Pointers SHALL be $clog2(DEPTH)+1 bits wide with wrap-around; full/empty derived from the MSB difference.
REQ-021 Each out handshake SHALL increment the pending credit counter by 1; pending never exceeds DEPTH.
REQ-022 Credit FSM states are IDLE, ACCUM and SEND.
  - IDLE: pending == 0, credit_valid = 0.
  - ACCUM: pending > 0; timer counts up from 0 each cycle.
  - SEND: credit_valid = 1.
REQ-023 IDLE->ACCUM SHALL occur in the cycle after pending becomes nonzero; timer SHALL be cleared on entry.
REQ-024 ACCUM->SEND SHALL occur when pending >= THRESHOLD or timer == TIMEOUT-1, whichever comes first.
REQ-025 On entering SEND, credit_count SHALL latch pending and stay stable until the handshake.
REQ-026 On credit handshake, pending <= pending - credit_count + (out handshake this cycle).
REQ-027 After a credit handshake, the FSM SHALL go to IDLE if the resulting pending is 0, else to ACCUM with timer cleared.
REQ-028 Drains during SEND SHALL add to pending only, never to the latched credit_count.
REQ-029 With no out handshakes, credit_valid SHALL remain 0 indefinitely (no unnecessary credit traffic).
REQ-030 Sum of occupancy, pending and credits in flight from this block SHALL never exceed DEPTH; the sender starts with DEPTH credits.

Reset
REQ-031 Asserting rst SHALL immediately clear the pointers, pending, timer and overflow, and set the FSM to IDLE.
REQ-032 During reset, out_valid = 0, credit_valid = 0, credit_count = 0 and overflow = 0; out_payload is don't-care.
REQ-033 Reset mid-transfer SHALL discard buffered data and pending credits; no message is emitted for them.

Verification
REQ-034 Write 3 words A,B,C with out_ready = 0 -> out_valid = 1 from cycle 1; with out_ready = 1, A,B,C drain in order; with THRESHOLD = 4 and TIMEOUT = 16, credit_valid rises after 16 ACCUM cycles with credit_count = 3.
REQ-035 Fill 8 entries, write a 9th with no read -> overflow = 1, 9th word dropped, 8 words drain intact.
REQ-036 Full buffer, write and read in the same cycle -> write accepted, occupancy stays 8, overflow = 0.
REQ-037 Drain 4 words back-to-back -> SEND with credit_count = 4; hold credit_ready = 0 and drain 2 more -> credit_count stays 4; on handshake pending = 2 and FSM = ACCUM.
REQ-038 Assert rst while in SEND with 5 buffered words -> next cycle credit_valid = 0, out_valid = 0, FSM = IDLE.
REQ-039 Formal checks: FIFO ordering (Wolper-style data check), credit conservation per REQ-030, and eventual credit_valid after any drain given fair credit_ready.

Source files
------------

// File: rtl/credit_rx_buffer.sv
// Receive-side FIFO for a credit-based link: buffers payloads from the ARQ receiver and
// returns freed slots to the sender as batched credit messages (threshold- or timeout-driven).
module credit_rx_buffer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int THRESHOLD = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_payload,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_payload,
    output logic                         credit_valid,
    input  logic                         credit_ready,
    output logic [$clog2(DEPTH+1)-1:0]   credit_count,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW:0]   DEPTH_W     = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] THRESHOLD_W = CW'(THRESHOLD);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SEND
    } state_t;

    // ------------------------------------------------------------------
    // Payload FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             out_hs;
    logic             wr_en;
    logic             overflow_q;

    // The extra pointer MSB distinguishes a full buffer from an empty one.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_hs = out_valid && out_ready;
    assign wr_en  = in_valid && (!full || out_hs);

    assign out_valid   = !empty;
    assign out_payload = mem[rd_ptr[AW-1:0]];
    assign overflow    = overflow_q;

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_payload;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (out_hs) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_valid && full && !out_hs) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit return
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   pending;
    logic [CW-1:0]   pending_next;
    logic [CW:0]     pend_sum;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic            credit_hs;

    assign credit_valid = (state == ST_SEND);
    assign credit_count = count_q;
    assign credit_hs    = credit_valid && credit_ready;

    // Drains always add to pending; a returned message removes exactly what it carried.
    always_comb begin
        pend_sum = {1'b0, pending} + {{CW{1'b0}}, out_hs};
        if (credit_hs) begin
            pend_sum = pend_sum - {1'b0, count_q};
        end
        pending_next = (pend_sum > DEPTH_W) ? DEPTH_W[CW-1:0] : pend_sum[CW-1:0];
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        timer_next = timer;
        count_next = count_q;
        unique case (state)
            ST_IDLE: begin
                if (pending != '0) begin
                    state_next = ST_ACCUM;
                    timer_next = '0;
                end
            end
            ST_ACCUM: begin
                if (pending >= THRESHOLD_W || timer == TIMER_LAST) begin
                    state_next = ST_SEND;
                    count_next = pending;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            ST_SEND: begin
                if (credit_ready) begin
                    count_next = '0;
                    timer_next = '0;
                    state_next = (pending_next == '0) ? ST_IDLE : ST_ACCUM;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pending <= '0;
            timer   <= '0;
            count_q <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            timer   <= timer_next;
            count_q <= count_next;
        end
    end

endmodule

// File: tb/tb_credit_rx_buffer.sv
// Self-checking bench for credit_rx_buffer: directed scenarios plus credit-respecting
// random traffic, all compared cycle by cycle against a queue-based reference model.
module tb_credit_rx_buffer;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 8;
    localparam int THRESHOLD = 4;
    localparam int TIMEOUT   = 16;
    localparam int CW        = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_payload = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_payload;
    logic             credit_valid;
    logic             credit_ready = 1'b0;
    logic [CW-1:0]    credit_count;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a payload queue plus the credit bookkeeping in plain integers.
    logic [WIDTH-1:0] m_q[$];
    int  m_pending;
    int  m_age;
    int  m_count;
    bit  m_accum;
    bit  m_offer;
    bit  m_ovf;
    int  sender_credits;

    credit_rx_buffer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .THRESHOLD(THRESHOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .credit_valid(credit_valid), .credit_ready(credit_ready), .credit_count(credit_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pending      = 0;
        m_age          = 0;
        m_count        = 0;
        m_accum        = 1'b0;
        m_offer        = 1'b0;
        m_ovf          = 1'b0;
        sender_credits = DEPTH;
    endtask

    task automatic compare_outputs();
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check("out_payload", 64'(out_payload), 64'(m_q[0]));
        check("credit_valid", 64'(credit_valid), 64'(m_offer));
        check("credit_count", 64'(credit_count), 64'(m_count));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // Drive one cycle of inputs, compare outputs, advance the model and the clock.
    task automatic step(input bit iv, input logic [WIDTH-1:0] ip, input bit ordy, input bit crdy);
        bit o_hs;
        bit c_hs;
        int old_p;
        int new_p;
        in_valid     = iv;
        in_payload   = ip;
        out_ready    = ordy;
        credit_ready = crdy;
        compare_outputs();
        o_hs = ordy && (m_q.size() != 0);
        c_hs = crdy && m_offer;
        if (o_hs) void'(m_q.pop_front());
        if (iv) begin
            if (m_q.size() < DEPTH) m_q.push_back(ip);
            else m_ovf = 1'b1;
        end
        if (c_hs) sender_credits += m_count;
        old_p = m_pending;
        new_p = old_p + int'(o_hs) - (c_hs ? m_count : 0);
        if (new_p > DEPTH) new_p = DEPTH;
        if (m_offer) begin
            if (c_hs) begin
                m_offer = 1'b0;
                m_count = 0;
                m_accum = (new_p != 0);
                m_age   = 0;
            end
        end else if (m_accum) begin
            if (old_p >= THRESHOLD || m_age == TIMEOUT - 1) begin
                m_offer = 1'b1;
                m_count = old_p;
                m_accum = 1'b0;
            end else begin
                m_age++;
            end
        end else if (old_p != 0) begin
            m_accum = 1'b1;
            m_age   = 0;
        end
        m_pending = new_p;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and confirm the outputs clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst credit_valid", 64'(credit_valid), 64'd0);
        check("rst credit_count", 64'(credit_count), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        model_reset();
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        credit_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_credit(input int limit);
        int n;
        n = 0;
        while (!credit_valid && n < limit) begin
            step(1'b0, '0, 1'b0, 1'b0);
            n++;
        end
        check("credit wait bound", 64'(credit_valid), 64'd1);
    endtask

    initial begin
        int cyc;
        int cnt;
        bit iv;
        bit ordy;
        bit crdy;

        model_reset();
        do_reset();

        // Three words, held then drained; only the timeout can release their credits.
        step(1'b1, 32'hA000_000A, 1'b0, 1'b0);
        step(1'b1, 32'hB000_000B, 1'b0, 1'b0);
        step(1'b1, 32'hC000_000C, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("abc held payload", 64'(out_payload), 64'h0000_0000_A000_000A);
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            cyc++;
        end
        while (!credit_valid && cyc < 60) begin
            step(1'b0, '0, 1'b0, 1'b0);
            cyc++;
        end
        check("abc credit latency", 64'(cyc), 64'd18);
        check("abc credit_count", 64'(credit_count), 64'd3);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("no spurious credit", 64'(credit_valid), 64'd0);

        // Overflow: ninth write dropped, eight originals intact.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, WIDTH'(32'h1100_0000 + i), 1'b0, 1'b0);
        check("overflow set", 64'(overflow), 64'd1);
        cnt = 0;
        while (out_valid && cnt < 20) begin
            step(1'b0, '0, 1'b1, 1'b0);
            cnt++;
        end
        check("overflow drained", 64'(cnt), 64'd8);
        check("overflow sticky", 64'(overflow), 64'd1);

        // Full buffer with simultaneous write and read.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(32'h2200_0000 + i), 1'b0, 1'b0);
        step(1'b1, 32'h2200_00FF, 1'b1, 1'b0);
        check("full rw overflow", 64'(overflow), 64'd0);
        cnt = 0;
        while (out_valid && cnt < 20) begin
            step(1'b0, '0, 1'b1, 1'b0);
            cnt++;
        end
        check("full rw drained", 64'(cnt), 64'd8);

        // Threshold message, extra drains while it is held, then the remainder.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(32'h3300_0000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        wait_credit(10);
        check("threshold count", 64'(credit_count), 64'd4);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("held count", 64'(credit_count), 64'd4);
        step(1'b0, '0, 1'b0, 1'b1);
        check("after handshake", 64'(credit_valid), 64'd0);
        wait_credit(40);
        check("remainder count", 64'(credit_count), 64'd2);
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset while a message is offered and five words are buffered.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(32'h4400_0000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h4400_0008, 1'b0, 1'b0);
        wait_credit(10);
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("post reset silent", 64'(credit_valid), 64'd0);

        // Random traffic from a sender that honours its credit budget.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            iv   = ($urandom_range(2) != 0) && (sender_credits > 0);
            ordy = (i < 1500) ? ($urandom_range(1) == 1) : ($urandom_range(4) != 0);
            crdy = ($urandom_range(3) == 0);
            if (iv) sender_credits--;
            step(iv, WIDTH'($urandom), ordy, crdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
